ap_table_reg_master: RTL and testbench

Register-ring initiator for the action-pointer table: it converts a local "write entry" or "read entry" command into the indirect-access register sequence that the table's register block expects. It sits at the head of a UDP register ring segment and injects requests. It matches returning responses by source ID and delivers the full ACTION_WIDTH entry, plus an error flag, to the local controller. It is the requester counterpart of the table-side register responder.

---
 rtl/ap_table_reg_master_pkg.sv | 50 +++++
 rtl/ap_table_reg_master.sv | 171 +++++++++++++++++
 tb/tb_ap_table_reg_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_table_reg_master_pkg.sv
// ============================================================================
// Module      : ap_table_reg_master_pkg
// Description : Shared constants, helpers and FSM encoding for the
//               action-pointer table register master and responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ap_table_reg_master_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } apt_state_t;

    function automatic int ap_ceildiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Never returns 0 so a depth-1 table still gets a legal index port.
    function automatic int ap_log2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Indirect-access offsets sit directly above the N data words.
    function automatic int ap_read_addr(input int n_words);
        return n_words;
    endfunction

    function automatic int ap_write_addr(input int n_words);
        return n_words + 1;
    endfunction

    function automatic int ap_table_size_addr(input int n_words);
        return n_words + 2;
    endfunction

    localparam int APT_WORDS       = ap_ceildiv(160, 32);
    localparam int READ_ADDR       = ap_read_addr(APT_WORDS);
    localparam int WRITE_ADDR      = ap_write_addr(APT_WORDS);
    localparam int TABLE_SIZE_ADDR = ap_table_size_addr(APT_WORDS);

endpackage

`default_nettype wire

// File: rtl/ap_table_reg_master.sv
// ============================================================================
// Module      : ap_table_reg_master
// Description : Register-ring initiator that turns table read/write commands
//               into indirect-access register transactions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_table_reg_master
    import ap_table_reg_master_pkg::*;
#(
    parameter int ACTION_WIDTH      = 160,
    parameter int APT_DEPTH         = 8,
    parameter int APT_DEPTH_BITS    = ap_log2(APT_DEPTH),
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID = 2'd1,
    parameter int REG_ADDR_WIDTH    = 10,
    parameter logic [UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] TAG = 13'h1,
    parameter int TIMEOUT           = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_vld,
    input  logic                            cmd_rd_wr_L,
    input  logic [APT_DEPTH_BITS-1:0]       cmd_index,
    input  logic [ACTION_WIDTH-1:0]         cmd_action,
    output logic                            cmd_rdy,
    output logic                            rsp_vld,
    output logic                            rsp_err,
    output logic [ACTION_WIDTH-1:0]         rsp_action,
    output logic                            reg_req_out,
    output logic                            reg_ack_out,
    output logic                            reg_rd_wr_L_out,
    output logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,
    input  logic                            reg_req_in,
    input  logic                            reg_ack_in,
    input  logic                            reg_rd_wr_L_in,
    input  logic [UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
    input  logic [CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in
);

    localparam int N         = ap_ceildiv(ACTION_WIDTH, 32);
    localparam int DATA_BITS = N * 32;
    localparam int STEP_W    = ap_log2(N + 1);
    localparam int TMR_W     = ap_log2(TIMEOUT);

    localparam logic [STEP_W-1:0]         c_last_step  = STEP_W'(N);
    localparam logic [TMR_W-1:0]          c_tmo_last   = TMR_W'(TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] c_read_addr  = REG_ADDR_WIDTH'(ap_read_addr(N));
    localparam logic [REG_ADDR_WIDTH-1:0] c_write_addr = REG_ADDR_WIDTH'(ap_write_addr(N));

    apt_state_t                  r_state;
    apt_state_t                  w_next;
    logic                        r_rd;
    logic [APT_DEPTH_BITS-1:0]   r_index;
    logic [DATA_BITS-1:0]        r_words;
    logic [STEP_W-1:0]           r_step;
    logic [TMR_W-1:0]            r_timer;
    logic                        r_err;
    logic                        w_match;
    logic                        w_timeout;
    logic [STEP_W-1:0]           w_rd_word;
    logic [REG_ADDR_WIDTH-1:0]   w_offset;
    logic                        w_unused;

    assign w_match   = reg_req_in && (reg_src_in == SRC_ID);
    assign w_timeout = (r_timer == c_tmo_last);
    // Read sequence spends step 0 on the READ_ADDR write, so word k is step k+1.
    assign w_rd_word = r_step - STEP_W'(1);
    assign w_unused  = ^{reg_rd_wr_L_in, reg_addr_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_rd    <= 1'b0;
            r_index <= '0;
            r_words <= '0;
            r_step  <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        r_rd    <= cmd_rd_wr_L;
                        r_index <= cmd_index;
                        r_words <= cmd_rd_wr_L ? '0 : DATA_BITS'(cmd_action);
                        r_step  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT_RSP: begin
                    if (w_match) begin
                        if (!reg_ack_in) begin
                            r_err <= 1'b1;
                        end else begin
                            if (r_rd && (r_step != '0)) begin
                                r_words[32*int'(w_rd_word) +: 32] <= reg_data_in;
                            end
                            r_step <= r_step + STEP_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (cmd_vld) w_next = ST_ISSUE;
            ST_ISSUE:    w_next = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (w_match) begin
                    w_next = (!reg_ack_in || (r_step == c_last_step)) ? ST_DONE : ST_ISSUE;
                end else if (w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        reg_req_out     = 1'b0;
        reg_rd_wr_L_out = 1'b0;
        reg_data_out    = '0;
        reg_src_out     = '0;
        w_offset        = '0;
        if (r_state == ST_ISSUE) begin
            reg_req_out = 1'b1;
            reg_src_out = SRC_ID;
            if (r_rd) begin
                if (r_step == '0) begin
                    w_offset     = c_read_addr;
                    reg_data_out = CPCI_NF2_DATA_WIDTH'(r_index);
                end else begin
                    reg_rd_wr_L_out = 1'b1;
                    w_offset        = REG_ADDR_WIDTH'(w_rd_word);
                end
            end else if (r_step == c_last_step) begin
                w_offset     = c_write_addr;
                reg_data_out = CPCI_NF2_DATA_WIDTH'(r_index);
            end else begin
                w_offset     = REG_ADDR_WIDTH'(r_step);
                reg_data_out = r_words[32*int'(r_step) +: 32];
            end
        end
    end

    assign reg_addr_out = (r_state == ST_ISSUE) ? {TAG, w_offset} : '0;
    assign reg_ack_out  = 1'b0;
    assign cmd_rdy      = (r_state == ST_IDLE);
    assign rsp_vld      = (r_state == ST_DONE);
    assign rsp_err      = (r_state == ST_DONE) && r_err;
    assign rsp_action   = ((r_state == ST_DONE) && r_rd && !r_err) ? r_words[ACTION_WIDTH-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ap_table_reg_master.sv
// ============================================================================
// Module      : tb_ap_table_reg_master
// Description : Directed self-checking bench with a ring responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ap_table_reg_master;

    logic         clk;
    logic         reset;
    logic         cmd_vld;
    logic         cmd_rd_wr_L;
    logic [2:0]   cmd_index;
    logic [159:0] cmd_action;
    logic         cmd_rdy;
    logic         rsp_vld;
    logic         rsp_err;
    logic [159:0] rsp_action;
    logic         reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [22:0]  reg_addr_out;
    logic [31:0]  reg_data_out;
    logic [1:0]   reg_src_out;
    logic         reg_req_in, reg_ack_in, reg_rd_wr_L_in;
    logic [22:0]  reg_addr_in;
    logic [31:0]  reg_data_in;
    logic [1:0]   reg_src_in;

    ap_table_reg_master dut (
        .clk(clk), .reset(reset),
        .cmd_vld(cmd_vld), .cmd_rd_wr_L(cmd_rd_wr_L), .cmd_index(cmd_index),
        .cmd_action(cmd_action), .cmd_rdy(cmd_rdy),
        .rsp_vld(rsp_vld), .rsp_err(rsp_err), .rsp_action(rsp_action),
        .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
        .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
        .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
        .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
        .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
        .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    localparam logic [159:0] c_act_a = 160'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF;
    localparam logic [159:0] c_act_b = 160'h11111111_22222222_33333333_44444444_55555555;
    localparam logic [31:0]  c_words_a [5] = '{32'hDEADBEEF, 32'h76543210, 32'hFEDCBA98,
                                               32'h89ABCDEF, 32'h01234567};

    // Responder model controls and transaction log
    int          rsp_lat = 2;
    bit          silent  = 0;
    bit          foreign = 0;
    int          nack_at = -1;
    int          txn_no  = 0;
    int          n_req   = 0;
    logic [22:0] log_addr [16];
    logic [31:0] log_data [16];
    logic        log_rw   [16];
    logic [1:0]  log_src  [16];
    logic        log_ack  [16];
    logic [31:0] tbl   [8][5];
    logic [31:0] stage [5];

    initial begin
        logic [22:0] a;
        logic [31:0] d, rdata;
        logic        rw, ack;
        int          off;
        reg_req_in = 0; reg_ack_in = 0; reg_rd_wr_L_in = 0;
        reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 5; j++) tbl[i][j] = '0;
        for (int j = 0; j < 5; j++) stage[j] = '0;
        forever begin
            @(negedge clk);
            if (reg_req_out) begin
                a = reg_addr_out; d = reg_data_out; rw = reg_rd_wr_L_out;
                if (n_req < 16) begin
                    log_addr[n_req] = a; log_data[n_req] = d; log_rw[n_req] = rw;
                    log_src[n_req] = reg_src_out; log_ack[n_req] = reg_ack_out;
                end
                n_req++;
                txn_no++;
                off = int'(a[9:0]);
                rdata = d;
                if (rw) begin
                    rdata = (off < 5) ? stage[off] : 32'h0;
                end else if (off < 5) begin
                    stage[off] = d;
                end else if (off == 5) begin
                    for (int j = 0; j < 5; j++) stage[j] = tbl[d[2:0]][j];
                end else if (off == 6) begin
                    for (int j = 0; j < 5; j++) tbl[d[2:0]][j] = stage[j];
                end
                ack = (txn_no != nack_at);
                if (!silent) begin
                    for (int k = 1; k <= rsp_lat; k++) begin
                        @(posedge clk); #1;
                        if (k == rsp_lat) begin
                            reg_req_in = 1; reg_ack_in = ack; reg_src_in = 2'd1;
                            reg_rd_wr_L_in = rw; reg_addr_in = a; reg_data_in = rdata;
                        end else if (foreign && k == rsp_lat - 1) begin
                            reg_req_in = 1; reg_ack_in = 1; reg_src_in = 2'd2;
                            reg_rd_wr_L_in = rw; reg_addr_in = a; reg_data_in = 32'hBAD0BAD0;
                        end else begin
                            reg_req_in = 0; reg_ack_in = 0; reg_src_in = '0;
                        end
                    end
                    @(posedge clk); #1;
                    reg_req_in = 0; reg_ack_in = 0; reg_src_in = '0;
                    reg_rd_wr_L_in = 0; reg_addr_in = '0; reg_data_in = '0;
                end
            end
        end
    end

    // Drive a command at a negedge; acceptance happens on the following edge.
    task automatic start_cmd(input logic rd, input logic [2:0] idx, input logic [159:0] act);
        @(negedge clk);
        n_req = 0; txn_no = 0;
        cmd_vld = 1; cmd_rd_wr_L = rd; cmd_index = idx; cmd_action = act;
        @(negedge clk);
        cmd_vld = 0; cmd_rd_wr_L = ~rd; cmd_index = ~idx; cmd_action = ~act;
    endtask

    task automatic wait_rsp(output int lat, output logic err, output logic [159:0] act);
        lat = -1; err = 1'bx; act = 'x;
        for (int k = 1; k <= 300; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_vld) begin
                lat = k; err = rsp_err; act = rsp_action;
                break;
            end
        end
    endtask

    int           lat;
    logic         err;
    logic [159:0] act;
    int           stray;

    initial begin
        reset = 1; cmd_vld = 0; cmd_rd_wr_L = 0; cmd_index = '0; cmd_action = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rdy", 160'(cmd_rdy), 160'd1);
        chk("rst_rsp_vld", 160'(rsp_vld), 160'd0);
        chk("rst_req_out", 160'(reg_req_out), 160'd0);
        chk("rst_addr_out", 160'(reg_addr_out), 160'd0);
        reset = 0;

        // Write idx 3
        start_cmd(1'b0, 3'd3, c_act_a);
        wait_rsp(lat, err, act);
        chk("wr_latency", 160'(lat), 160'd19);
        chk("wr_err", 160'(err), 160'd0);
        chk("wr_action", act, 160'd0);
        @(negedge clk);
        chk("wr_rsp_pulse", 160'(rsp_vld), 160'd0);
        chk("wr_cmd_rdy", 160'(cmd_rdy), 160'd1);
        chk("wr_n_req", 160'(n_req), 160'd6);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("wr_addr%0d", i), 160'(log_addr[i]), 160'(23'h400 + 23'(i)));
            chk($sformatf("wr_data%0d", i), 160'(log_data[i]), 160'(c_words_a[i]));
            chk($sformatf("wr_rw%0d", i), 160'(log_rw[i]), 160'd0);
        end
        chk("wr_addr_commit", 160'(log_addr[5]), 160'h406);
        chk("wr_data_commit", 160'(log_data[5]), 160'd3);
        chk("wr_src", 160'(log_src[5]), 160'd1);
        chk("wr_ack_out", 160'(log_ack[0]), 160'd0);

        // Read idx 3
        start_cmd(1'b1, 3'd3, 160'd0);
        wait_rsp(lat, err, act);
        chk("rd_latency", 160'(lat), 160'd19);
        chk("rd_err", 160'(err), 160'd0);
        chk("rd_action", act, c_act_a);
        repeat (2) @(negedge clk);
        chk("rd_addr0", 160'(log_addr[0]), 160'h405);
        chk("rd_data0", 160'(log_data[0]), 160'd3);
        chk("rd_rw0", 160'(log_rw[0]), 160'd0);
        for (int i = 1; i < 6; i++) begin
            chk($sformatf("rd_addr%0d", i), 160'(log_addr[i]), 160'(23'h400 + 23'(i - 1)));
            chk($sformatf("rd_rw%0d", i), 160'(log_rw[i]), 160'd1);
        end

        // Nack on the second transaction
        nack_at = 2;
        start_cmd(1'b1, 3'd3, 160'd0);
        wait_rsp(lat, err, act);
        chk("nack_latency", 160'(lat), 160'd7);
        chk("nack_err", 160'(err), 160'd1);
        chk("nack_action", act, 160'd0);
        repeat (10) @(negedge clk);
        chk("nack_n_req", 160'(n_req), 160'd2);
        nack_at = -1;

        // No responder at all: timeout
        silent = 1;
        start_cmd(1'b0, 3'd1, c_act_b);
        wait_rsp(lat, err, act);
        chk("tmo_latency", 160'(lat), 160'd66);
        chk("tmo_err", 160'(err), 160'd1);
        chk("tmo_action", act, 160'd0);
        chk("tmo_n_req", 160'(n_req), 160'd1);
        silent = 0;
        repeat (2) @(negedge clk);

        // Foreign-source return ahead of each real one
        foreign = 1;
        start_cmd(1'b1, 3'd3, 160'd0);
        wait_rsp(lat, err, act);
        chk("frn_latency", 160'(lat), 160'd19);
        chk("frn_err", 160'(err), 160'd0);
        chk("frn_action", act, c_act_a);
        foreign = 0;
        repeat (3) @(negedge clk);

        // Reset during the third transaction, late return afterwards
        start_cmd(1'b0, 3'd3, c_act_b);
        repeat (7) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mrst_cmd_rdy", 160'(cmd_rdy), 160'd1);
        chk("mrst_req_out", 160'(reg_req_out), 160'd0);
        chk("mrst_rsp_vld", 160'(rsp_vld), 160'd0);
        chk("mrst_n_req", 160'(n_req), 160'd3);
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_vld || reg_req_out || !cmd_rdy) stray++;
        end
        chk("mrst_quiet", 160'(stray), 160'd0);
        start_cmd(1'b1, 3'd3, 160'd0);
        wait_rsp(lat, err, act);
        chk("post_rst_latency", 160'(lat), 160'd19);
        chk("post_rst_err", 160'(err), 160'd0);
        chk("post_rst_action", act, c_act_a);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
